// File: rtl/game_pkg.sv
// ============================================================
// game_pkg : shared state codes, default parameters, BCD helper
// Rev 1.0
// ============================================================
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_ARM   = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DYING = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int unsigned c_reset_frames_dflt = 2;
  localparam int unsigned c_death_frames_dflt = 60;
  localparam int unsigned c_boss_score_dflt   = 20;

  localparam int unsigned c_frame_w = 8;
  localparam int unsigned c_kill_w  = 14;
  localparam logic [15:0] c_bcd_max = 16'h9999;

  function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_score_counter.sv
// ============================================================
// bcd_score_counter : four-digit BCD up-counter, saturating at 9999
// Rev 1.0
// ============================================================
`default_nettype none

module bcd_score_counter
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic        o_sat,
  output logic [15:0] o_value
);

  logic [15:0] r_value;
  logic [3:0]  w_carry;

  assign o_sat      = (r_value == c_bcd_max);
  assign o_value    = r_value;
  assign w_carry[0] = i_inc & ~o_sat;

  // A digit advances only when every lower digit is about to roll over.
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_carry
      assign w_carry[gi] = w_carry[gi-1] & (r_value[(gi-1)*4 +: 4] == 4'd9);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_clr) begin
      r_value <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_carry[i]) r_value[i*4 +: 4] <= bcd_digit_inc(r_value[i*4 +: 4]);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_flow_ctrl.sv
// ============================================================
// game_flow_ctrl : game screen sequencer, score and boss request
// Rev 1.0
// ============================================================
`default_nettype none

module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned RESET_FRAMES = c_reset_frames_dflt,
  parameter int unsigned DEATH_FRAMES = c_death_frames_dflt,
  parameter int unsigned BOSS_SCORE   = c_boss_score_dflt
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enter,
  input  logic        i_vsync,
  input  logic [3:0]  i_present_health,
  input  logic        i_ep_boom,
  output logic        o_start_en,
  output logic        o_play_en,
  output logic        o_end_en,
  output logic        o_game_rst,
  output logic        o_blink,
  output logic [15:0] o_score,
  output logic        o_boss_req,
  output logic [2:0]  o_state
);

  localparam logic [c_frame_w-1:0] c_reset_frames = c_frame_w'(RESET_FRAMES);
  localparam logic [c_frame_w-1:0] c_death_frames = c_frame_w'(DEATH_FRAMES);
  localparam logic [c_kill_w-1:0]  c_boss_score   = c_kill_w'(BOSS_SCORE);

  state_t               r_state, w_state_nxt;
  logic                 r_enter_meta, r_enter_sync, r_enter_prev;
  logic [1:0]           r_prime;
  logic                 r_seen_low;
  logic                 r_vsync_d;
  logic [c_frame_w-1:0] r_frame_cnt;
  logic [c_frame_w-1:0] w_cnt_inc;
  logic [c_kill_w-1:0]  r_kill;
  logic                 r_start_en, r_play_en, r_end_en, r_game_rst, r_blink, r_boss_req;
  logic                 w_press, w_tick, w_inc, w_arm_entry, w_state_chg, w_score_sat;

  // r_prime marks when the sync flop holds a real sample rather than its reset value,
  // so enter held through reset cannot fake a low level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enter_meta <= 1'b0;
      r_enter_sync <= 1'b0;
      r_enter_prev <= 1'b0;
      r_prime      <= 2'b00;
      r_seen_low   <= 1'b0;
      r_vsync_d    <= 1'b0;
    end else begin
      r_enter_meta <= i_enter;
      r_enter_sync <= r_enter_meta;
      r_enter_prev <= r_enter_sync;
      r_prime      <= {r_prime[0], 1'b1};
      if (r_prime[1] && !r_enter_sync) r_seen_low <= 1'b1;
      r_vsync_d    <= i_vsync;
    end
  end

  assign w_press     = r_enter_sync & ~r_enter_prev & r_seen_low;
  assign w_tick      = r_vsync_d & ~i_vsync;
  assign w_cnt_inc   = r_frame_cnt + 1'b1;
  assign w_state_chg = (w_state_nxt != r_state);
  assign w_arm_entry = (w_state_nxt == ST_ARM) && (r_state != ST_ARM);
  assign w_inc       = i_ep_boom && (r_state == ST_PLAY);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_START: if (w_press) w_state_nxt = ST_ARM;
      ST_ARM:   if (w_tick && (w_cnt_inc >= c_reset_frames)) w_state_nxt = ST_PLAY;
      ST_PLAY:  if (i_present_health == 4'd0) w_state_nxt = ST_DYING;
      ST_DYING: if (w_tick && (w_cnt_inc >= c_death_frames)) w_state_nxt = ST_OVER;
      ST_OVER:  if (w_press) w_state_nxt = ST_ARM;
      default:  w_state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_START;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_chg) r_frame_cnt <= w_tick ? c_frame_w'(1) : '0;
      else if (w_tick) r_frame_cnt <= w_cnt_inc;
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_en <= 1'b1;
      r_play_en  <= 1'b0;
      r_end_en   <= 1'b0;
      r_game_rst <= 1'b0;
      r_blink    <= 1'b1;
    end else begin
      r_start_en <= (w_state_nxt == ST_START) || (w_state_nxt == ST_ARM);
      r_play_en  <= (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_DYING);
      r_end_en   <= (w_state_nxt == ST_OVER);
      r_game_rst <= (w_state_nxt == ST_ARM);
      if (w_state_nxt != ST_DYING) r_blink <= 1'b1;
      else if ((r_state == ST_DYING) && w_tick && (w_cnt_inc[2:0] == 3'd0)) r_blink <= ~r_blink;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kill     <= '0;
      r_boss_req <= 1'b0;
    end else if (w_arm_entry) begin
      r_kill     <= '0;
      r_boss_req <= 1'b0;
    end else begin
      if (w_inc && (r_kill != {c_kill_w{1'b1}})) r_kill <= r_kill + 1'b1;
      if (r_kill >= c_boss_score) r_boss_req <= 1'b1;
    end
  end

  bcd_score_counter u_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_inc & ~w_score_sat),
    .i_clr   (w_arm_entry),
    .o_sat   (w_score_sat),
    .o_value (o_score)
  );

  assign o_start_en = r_start_en;
  assign o_play_en  = r_play_en;
  assign o_end_en   = r_end_en;
  assign o_game_rst = r_game_rst;
  assign o_blink    = r_blink;
  assign o_boss_req = r_boss_req;
  assign o_state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
// ============================================================
// tb_game_flow_ctrl : directed self-checking bench for game_flow_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enter = 1'b0;
  logic        vsync = 1'b1;
  logic [3:0]  health = 4'd3;
  logic        ep_boom = 1'b0;
  logic        start_en, play_en, end_en, game_rst, blink, boss_req;
  logic [15:0] score;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_score = 16'h0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  game_flow_ctrl #(.RESET_FRAMES(2), .DEATH_FRAMES(60), .BOSS_SCORE(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_enter          (enter),
    .i_vsync          (vsync),
    .i_present_health (health),
    .i_ep_boom        (ep_boom),
    .o_start_en       (start_en),
    .o_play_en        (play_en),
    .o_end_en         (end_en),
    .o_game_rst       (game_rst),
    .o_blink          (blink),
    .o_score          (score),
    .o_boss_req       (boss_req),
    .o_state          (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    int n;
    n = v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    if (n < 9999) n++;
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_boom(input int n);
    for (int i = 0; i < n; i++) begin
      ep_boom = 1'b1;
      exp_score = bcd_inc(exp_score);
      sb_q.push_back(exp_score);
      @(negedge clk);
      chk("score", {16'h0, score}, {16'h0, sb_q.pop_front()});
    end
    ep_boom = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, {29'h0, state}, 32'd0);
    chk({tag, "_start_en"}, {31'h0, start_en}, 32'd1);
    chk({tag, "_play_en"}, {31'h0, play_en}, 32'd0);
    chk({tag, "_end_en"}, {31'h0, end_en}, 32'd0);
    chk({tag, "_game_rst"}, {31'h0, game_rst}, 32'd0);
    chk({tag, "_blink"}, {31'h0, blink}, 32'd1);
    chk({tag, "_score"}, {16'h0, score}, 32'd0);
    chk({tag, "_boss_req"}, {31'h0, boss_req}, 32'd0);
  endtask

  // Press: enter driven high, ARM expected on the third clock edge.
  task automatic press_to_arm(input string tag);
    enter = 1'b1;
    clks(2);
    chk({tag, "_pre_arm"}, {29'h0, state}, 32'd0 + ((tag == "over") ? 4 : 0));
    clks(1);
    chk({tag, "_arm"}, {29'h0, state}, 32'd1);
    chk({tag, "_arm_game_rst"}, {31'h0, game_rst}, 32'd1);
    chk({tag, "_arm_start_en"}, {31'h0, start_en}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clks(3);
    check_idle("reset");
    rst_n = 1'b1;
    clks(4);
    check_idle("released");

    // Game 1: start, score, boss, death, game over
    press_to_arm("start");
    frame();
    chk("arm_tick1_game_rst", {31'h0, game_rst}, 32'd1);
    chk("arm_tick1_state", {29'h0, state}, 32'd1);
    frame();
    chk("play_state", {29'h0, state}, 32'd2);
    chk("play_en", {31'h0, play_en}, 32'd1);
    chk("play_game_rst", {31'h0, game_rst}, 32'd0);
    chk("play_start_en", {31'h0, start_en}, 32'd0);

    pulse_boom(3);
    chk("boss_3rd_clk", {31'h0, boss_req}, 32'd0);
    pulse_boom(1);
    chk("boss_after", {31'h0, boss_req}, 32'd1);
    pulse_boom(8);
    chk("score_12", {16'h0, score}, 32'h0012);

    health = 4'd0;
    pulse_boom(1);
    chk("death_score", {16'h0, score}, 32'h0013);
    chk("death_state", {29'h0, state}, 32'd3);
    chk("death_blink", {31'h0, blink}, 32'd1);
    health = 4'd3;
    for (int t = 1; t <= 60; t++) begin
      frame();
      if (t < 60) begin
        chk("dying_state", {29'h0, state}, 32'd3);
        chk("dying_blink", {31'h0, blink}, ((t / 8) % 2 == 0) ? 32'd1 : 32'd0);
      end
    end
    chk("over_state", {29'h0, state}, 32'd4);
    chk("over_end_en", {31'h0, end_en}, 32'd1);
    chk("over_play_en", {31'h0, play_en}, 32'd0);
    chk("over_blink", {31'h0, blink}, 32'd1);

    clks(6);
    chk("over_held_enter", {29'h0, state}, 32'd4);
    enter = 1'b0;
    clks(4);
    press_to_arm("over");
    exp_score = 16'h0;
    chk("rearm_score", {16'h0, score}, 32'd0);
    chk("rearm_boss", {31'h0, boss_req}, 32'd0);

    // Game 2: saturation, then asynchronous reset mid-game
    frame();
    frame();
    chk("play2_state", {29'h0, state}, 32'd2);
    pulse_boom(9999);
    chk("score_9999", {16'h0, score}, 32'h9999);
    pulse_boom(1);
    chk("score_sat", {16'h0, score}, 32'h9999);
    chk("boss_play2", {31'h0, boss_req}, 32'd1);

    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    exp_score = 16'h0;
    clks(2);

    // Game 3: enter held through reset must not count as a press
    rst_n = 1'b1;
    clks(8);
    chk("held_enter_no_press", {29'h0, state}, 32'd0);
    chk("held_enter_game_rst", {31'h0, game_rst}, 32'd0);
    enter = 1'b0;
    clks(4);
    press_to_arm("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter RESET_FRAMES, default 2, frames game_rst is held in ARM (range 1..15).
REQ-002 Parameter DEATH_FRAMES, default 60, frames spent in DYING (range 1..255).
REQ-003 Parameter BOSS_SCORE, default 20, binary kill count at which boss_req sets (range 1..9999).
REQ-004 clk  in  1  system clock (25.175 MHz pixel clock domain).
REQ-005 rst  in  1  reset; one clock, reset asynchronous and active-low.
REQ-006 enter  in  1  keyboard Enter level, asynchronous to clk.
REQ-007 vsync  in  1  VGA vertical sync, active-low, same clk domain.
REQ-008 present_health  in  4  current player health, unsigned.
REQ-009 ep_boom  in  1  one-clk pulse per enemy destroyed.
REQ-010 start_en / play_en / end_en  out  1 each  screen-layer selects, exactly one high.
REQ-011 game_rst  out  1  synchronous clear to plane, bullet and boom sub-blocks.
REQ-012 blink  out  1  player-sprite visibility gate during DYING.
REQ-013 score  out  16  four BCD digits, [15:12] most significant.
REQ-014 boss_req  out  1  sticky request to spawn the boss.
REQ-015 state  out  3  current FSM state code, debug.

Function
REQ-016 enter SHALL pass a 2-flop synchroniser; press = synchronised 0->1 transition, one-clk pulse.
REQ-017 Frame tick SHALL be a one-clk pulse on each vsync 1->0 transition.
REQ-018 States: START=0, ARM=1, PLAY=2, DYING=3, OVER=4; codes 5-7 SHALL return to START next clk.
REQ-019 START: start_en=1; press -> ARM.
REQ-020 ARM: game_rst=1, start_en=1; score and boss_req cleared on entry; after RESET_FRAMES ticks -> PLAY.
REQ-021 PLAY: play_en=1; present_health==0 sampled -> DYING next clk.
REQ-022 DYING: play_en=1; blink toggles every 8 ticks, starts 1; after DEATH_FRAMES ticks -> OVER.
REQ-023 OVER: end_en=1; press -> ARM; press only counts if enter edge occurs in OVER.
REQ-024 blink SHALL be 1 in every state except DYING.
REQ-025 Presses in ARM, PLAY, DYING SHALL be ignored, not queued.
REQ-026 ep_boom SHALL increment score only in PLAY, BCD carry per digit, saturating at 9999.
REQ-027 ep_boom and health==0 in the same clk: score increments, then DYING.
REQ-028 A parallel binary kill counter (14 bit, saturating) SHALL set boss_req when >= BOSS_SCORE; boss_req holds until ARM.
REQ-029 Frame counter SHALL clear on every state change; tick on the transition clk counts in the new state.
REQ-030 All outputs registered; state change visible one clk after the causing event.

Reset
REQ-031 rst low: state=START, start_en=1, play_en=0, end_en=0, game_rst=0, blink=1, score=0, boss_req=0, counters and synchroniser flops 0.
REQ-032 rst asserted mid-game SHALL abandon the game immediately; no game_rst pulse until next ARM.
REQ-033 First press after rst release SHALL require enter seen low for at least one synchronised sample.

Structure
REQ-034 Shared package game_pkg SHALL hold the state enum, state codes and default parameter constants.
REQ-035 BCD digit chain SHALL be sub-module bcd_score_counter (inc, clr, sat -> 16-bit value).
REQ-036 Target size 150-300 lines RTL total.

Verification
REQ-037 rst release, enter 0->1 -> ARM after 3 clk, game_rst high for exactly 2 ticks, then play_en=1.
REQ-038 In PLAY, 12 ep_boom pulses -> score=16'h0012; 9999 then one more pulse -> score stays 16'h9999.
REQ-039 BOSS_SCORE=3, 3 pulses -> boss_req=1 on 3rd+1 clk; after OVER->ARM boss_req=0, score=0.
REQ-040 health forced 0 with ep_boom same clk -> score +1, DYING, blink toggles at ticks 8,16..; OVER after 60 ticks, end_en=1.
REQ-041 enter held high through DYING into OVER -> stays OVER; release then press -> ARM.
REQ-042 rst pulsed low in PLAY -> asynchronous return to START, all outputs at reset values before next clk edge.
